mux_2to1_beh: RTL and testbench
===============================

Name: mux_2to1_beh

Overview:
- Behavioural 2-to-1 multiplexer: combinational output OUT selects IN1 or IN2 under Select.
- Adds a registered copy of the mux output and a select-change flag, both clocked on clk with asynchronous active-low reset rst_n.
- Generic leaf datapath primitive, reused wherever a two-way data choice is needed, e.g. source selection ahead of a pipeline register.

Parameters:
- WIDTH, 1, data width of IN1, IN2, OUT, OUT_R.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into OUT_R on reset.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- IN1  input  WIDTH  data input selected when Select=0.
- IN2  input  WIDTH  data input selected when Select=1.
- Select  input  1  selector.
- OUT  output  WIDTH  combinational mux output.
- OUT_R  output  WIDTH  OUT registered on rising clk.
- SEL_CHG  output  1  registered one-cycle pulse when Select differs from its previous sampled value.

Behaviour:
- OUT = Select ? IN2 : IN1.
  - Purely combinational, zero latency, independent of clk and rst_n.
  - OUT stays valid during reset.
- X/Z handling on Select (simulation only):
  - If Select is X or Z and IN1==IN2 bitwise, OUT = IN1.
  - Otherwise OUT bits that differ between IN1 and IN2 are X.
- Truth table, WIDTH=1, as {Select,IN1,IN2} -> OUT:
  - 000->0, 001->0, 010->1, 011->1
  - 100->0, 101->1, 110->0, 111->1
- OUT_R:
  - rst_n low: forced to RESET_VAL immediately, without waiting for a clk edge.
  - Otherwise captures OUT on each rising clk edge; one-cycle latency.
- sel_q: internal register holding the previously sampled Select.
  - Reset to 0.
  - Updated every rising clk edge.
- SEL_CHG:
  - Reset to 0.
  - On each rising edge, SEL_CHG <= (Select != sel_q).
  - Stays high on consecutive cycles if Select toggles every cycle.
  - A Select glitch between edges is not detected.
- Reset mid-operation: OUT_R, SEL_CHG and sel_q clear asynchronously. OUT keeps following its inputs.
- Reset release: the first rising edge with rst_n high loads OUT_R normally. SEL_CHG fires on that edge if Select=1, because sel_q reset to 0.
- Simultaneous Select and data change: OUT reflects the new Select and the new data in the same delta. No priority issue.
- No handshake; inputs may change at any time.

Decomposition:
- No shared package required.
- Optionally place WIDTH default and RESET_VAL helper constants in a common datapath package if one exists.
- One natural sub-module, mux_2to1_comb: combinational select only.
  - The top instantiates it and adds the OUT_R and SEL_CHG registers.

Test Plan:
- Exhaustive sweep, WIDTH=1: reset, then step {Select,IN1,IN2} from 000 to 111 every 50 ns -> OUT = 0,0,1,1,0,1,0,1.
- Registered path: Select=0, IN1=1, IN2=0, wait one clk edge -> OUT_R=1. Then set Select=1 -> OUT=0 immediately, and OUT_R=0 only after the next rising edge.
- Async reset: OUT_R=1, drive rst_n=0 mid-cycle -> OUT_R=0 and SEL_CHG=0 before the next edge, while OUT still equals the selected input. Release -> OUT_R reloads on the next edge.
- SEL_CHG pulse: after reset with Select=0, set Select=1 for 3 cycles then 0 -> SEL_CHG = 1,0,0,1 on successive edges.
- X on Select: IN1=IN2=1, Select=X -> OUT=1. Then IN1=0, IN2=1, Select=X -> OUT=X.
- WIDTH=8: IN1=8'hA5, IN2=8'h3C -> OUT=8'hA5 with Select=0 and 8'h3C with Select=1. RESET_VAL=8'hFF -> OUT_R=8'hFF during reset.

Source files
------------

// File: rtl/mux_2to1_beh_pkg.sv
// -----------------------------------------------------------------------------
// mux_2to1_beh_pkg
// Shared constants and helpers for the 2-to-1 mux slice.
//   MUX_DEFAULT_WIDTH : default data width for the mux and its wrapper
//   sel_changed()     : compares the current select against the last sampled one
// -----------------------------------------------------------------------------
package mux_2to1_beh_pkg;

  localparam int MUX_DEFAULT_WIDTH = 1;

  // An X/Z on either operand propagates as X, so an unknown select does not
  // report a clean change in simulation.
  function automatic logic sel_changed(input logic cur, input logic prev);
    return cur ^ prev;
  endfunction

endpackage : mux_2to1_beh_pkg

// File: rtl/mux_2to1_comb.sv
// -----------------------------------------------------------------------------
// mux_2to1_comb
// Purely combinational two-way select.
// Ports:
//   in1_i  [WIDTH] : chosen when sel_i = 0
//   in2_i  [WIDTH] : chosen when sel_i = 1
//   sel_i          : selector
//   out_o  [WIDTH] : sel_i ? in2_i : in1_i
// -----------------------------------------------------------------------------
module mux_2to1_comb
  import mux_2to1_beh_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_o
);

  // The conditional operator merges the two operands bitwise when sel_i is
  // X/Z: agreeing bits pass through and disagreeing bits become X.
  assign out_o = sel_i ? in2_i : in1_i;

endmodule : mux_2to1_comb

// File: rtl/mux_2to1_beh.sv
// -----------------------------------------------------------------------------
// mux_2to1_beh
// Behavioural 2-to-1 mux with a registered copy of its output and a
// select-change flag.
// Ports:
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset (registers only)
//   IN1    [WIDTH] : selected when Select = 0
//   IN2    [WIDTH] : selected when Select = 1
//   Select         : selector
//   OUT    [WIDTH] : combinational mux output, valid during reset
//   OUT_R  [WIDTH] : OUT registered, RESET_VAL while in reset
//   SEL_CHG        : one-cycle registered pulse when Select differs from the
//                    value sampled on the previous edge
// -----------------------------------------------------------------------------
module mux_2to1_beh
  import mux_2to1_beh_pkg::*;
#(
  parameter int               WIDTH     = MUX_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic             Select,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_R,
  output logic             SEL_CHG
);

  logic [WIDTH-1:0] mux_w;
  logic [WIDTH-1:0] out_r_d, out_r_q;
  logic             sel_d, sel_q;
  logic             sel_chg_d, sel_chg_q;

  mux_2to1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .in1_i (IN1),
    .in2_i (IN2),
    .sel_i (Select),
    .out_o (mux_w)
  );

  always_comb begin
    out_r_d   = mux_w;
    sel_d     = Select;
    sel_chg_d = sel_changed(Select, sel_q);
  end

  // sel_q clears to 0, so leaving reset with Select = 1 raises SEL_CHG on
  // the first edge. Changes of Select between edges are not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r_q   <= RESET_VAL;
      sel_q     <= 1'b0;
      sel_chg_q <= 1'b0;
    end else begin
      out_r_q   <= out_r_d;
      sel_q     <= sel_d;
      sel_chg_q <= sel_chg_d;
    end
  end

  assign OUT     = mux_w;
  assign OUT_R   = out_r_q;
  assign SEL_CHG = sel_chg_q;

endmodule : mux_2to1_beh

// File: tb/tb_mux_2to1_beh.sv
// -----------------------------------------------------------------------------
// tb_mux_2to1_beh
// Directed bench for mux_2to1_beh: a WIDTH=1 instance and a WIDTH=8 instance
// with RESET_VAL=8'hFF, sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_mux_2to1_beh;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic       in1 = 1'b0, in2 = 1'b0, sel = 1'b0;
  logic       out1, out_r1, sel_chg1;

  logic [7:0] in1_8 = 8'h00, in2_8 = 8'h00;
  logic       sel8  = 1'b0;
  logic [7:0] out8, out_r8;
  logic       sel_chg8;

  int n_cmp = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  mux_2to1_beh #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .IN1     (in1),
    .IN2     (in2),
    .Select  (sel),
    .OUT     (out1),
    .OUT_R   (out_r1),
    .SEL_CHG (sel_chg1)
  );

  mux_2to1_beh #(
    .WIDTH     (8),
    .RESET_VAL (8'hFF)
  ) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .IN1     (in1_8),
    .IN2     (in2_8),
    .Select  (sel8),
    .OUT     (out8),
    .OUT_R   (out_r8),
    .SEL_CHG (sel_chg8)
  );

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    n_cmp++; if (out_r1 !== 1'b0) begin n_err++; $display("FAIL reset_out_r1 got=%b want=0", out_r1); end
    n_cmp++; if (sel_chg1 !== 1'b0) begin n_err++; $display("FAIL reset_sel_chg1 got=%b want=0", sel_chg1); end
    n_cmp++; if (out_r8 !== 8'hFF) begin n_err++; $display("FAIL reset_out_r8 got=%h want=ff", out_r8); end
    n_cmp++; if (sel_chg8 !== 1'b0) begin n_err++; $display("FAIL reset_sel_chg8 got=%b want=0", sel_chg8); end
    // Held reset must survive clock edges.
    in1 = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_r1 !== 1'b0) begin n_err++; $display("FAIL reset_hold_out_r1 got=%b want=0", out_r1); end
    n_cmp++; if (out1 !== 1'b1) begin n_err++; $display("FAIL reset_out_live got=%b want=1", out1); end
    in1 = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] exp_vec;
    logic [2:0] v;
    exp_vec = 8'b1010_1100;  // OUT for {Select,IN1,IN2} = 7..0
    for (int i = 0; i < 8; i++) begin
      v   = i[2:0];
      sel = v[2];
      in1 = v[1];
      in2 = v[0];
      #1;
      n_cmp++;
      if (out1 !== exp_vec[i])
        begin n_err++; $display("FAIL sweep_%0d got=%b want=%b", i, out1, exp_vec[i]); end
      #49;
    end
  endtask

  task automatic test_width8();
    @(negedge clk);
    rst_n = 1'b1;
    in1_8 = 8'hA5; in2_8 = 8'h3C; sel8 = 1'b0;
    #1;
    n_cmp++; if (out8 !== 8'hA5) begin n_err++; $display("FAIL w8_out_sel0 got=%h want=a5", out8); end
    @(posedge clk); #1;
    n_cmp++; if (out_r8 !== 8'hA5) begin n_err++; $display("FAIL w8_out_r_sel0 got=%h want=a5", out_r8); end
    @(negedge clk);
    sel8 = 1'b1;
    #1;
    n_cmp++; if (out8 !== 8'h3C) begin n_err++; $display("FAIL w8_out_sel1 got=%h want=3c", out8); end
    @(posedge clk); #1;
    n_cmp++; if (out_r8 !== 8'h3C) begin n_err++; $display("FAIL w8_out_r_sel1 got=%h want=3c", out_r8); end
    n_cmp++; if (sel_chg8 !== 1'b1) begin n_err++; $display("FAIL w8_sel_chg got=%b want=1", sel_chg8); end
  endtask

  task automatic test_registered();
    @(negedge clk);
    sel = 1'b0; in1 = 1'b1; in2 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_r1 !== 1'b1) begin n_err++; $display("FAIL reg_capture got=%b want=1", out_r1); end
    sel = 1'b1;
    #1;
    n_cmp++; if (out1 !== 1'b0) begin n_err++; $display("FAIL reg_out_immediate got=%b want=0", out1); end
    n_cmp++; if (out_r1 !== 1'b1) begin n_err++; $display("FAIL reg_out_r_held got=%b want=1", out_r1); end
    @(posedge clk); #1;
    n_cmp++; if (out_r1 !== 1'b0) begin n_err++; $display("FAIL reg_out_r_update got=%b want=0", out_r1); end
  endtask

  task automatic test_async_reset();
    // Select was 1 last edge; dropping it makes SEL_CHG high before reset.
    @(negedge clk);
    sel = 1'b0; in1 = 1'b1; in2 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_r1 !== 1'b1) begin n_err++; $display("FAIL ar_pre_out_r got=%b want=1", out_r1); end
    n_cmp++; if (sel_chg1 !== 1'b1) begin n_err++; $display("FAIL ar_pre_sel_chg got=%b want=1", sel_chg1); end
    n_cmp++; if (out_r8 !== 8'h3C) begin n_err++; $display("FAIL ar_pre_out_r8 got=%h want=3c", out_r8); end
    #4 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_r1 !== 1'b0) begin n_err++; $display("FAIL ar_out_r got=%b want=0", out_r1); end
    n_cmp++; if (sel_chg1 !== 1'b0) begin n_err++; $display("FAIL ar_sel_chg got=%b want=0", sel_chg1); end
    n_cmp++; if (out1 !== 1'b1) begin n_err++; $display("FAIL ar_out_live got=%b want=1", out1); end
    n_cmp++; if (out_r8 !== 8'hFF) begin n_err++; $display("FAIL ar_out_r8 got=%h want=ff", out_r8); end
    n_cmp++; if (out8 !== 8'h3C) begin n_err++; $display("FAIL ar_out8_live got=%h want=3c", out8); end
    in1 = 1'b0;
    #1;
    n_cmp++; if (out1 !== 1'b0) begin n_err++; $display("FAIL ar_out_follow got=%b want=0", out1); end
    in1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_r1 !== 1'b1) begin n_err++; $display("FAIL ar_reload got=%b want=1", out_r1); end
    n_cmp++; if (sel_chg1 !== 1'b0) begin n_err++; $display("FAIL ar_release_sel_chg got=%b want=0", sel_chg1); end
  endtask

  task automatic test_sel_chg();
    logic [3:0] exp_seq;
    exp_seq = 4'b1001;  // edges 1..4 read from bit 3 down
    @(negedge clk);
    rst_n = 1'b0; sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin @(negedge clk); sel = 1'b0; end
      @(posedge clk); #1;
      n_cmp++;
      if (sel_chg1 !== exp_seq[3-k])
        begin n_err++; $display("FAIL selchg_pulse_%0d got=%b want=%b", k, sel_chg1, exp_seq[3-k]); end
    end
    // Toggling every cycle keeps the flag high.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); sel = ~sel;
      @(posedge clk); #1;
      n_cmp++;
      if (sel_chg1 !== 1'b1) begin n_err++; $display("FAIL selchg_toggle_%0d got=%b want=1", k, sel_chg1); end
    end
    @(posedge clk); #1;
    n_cmp++; if (sel_chg1 !== 1'b0) begin n_err++; $display("FAIL selchg_hold got=%b want=0", sel_chg1); end
    // Leaving reset with Select=1 fires because sel_q cleared to 0.
    @(negedge clk);
    rst_n = 1'b0; sel = 1'b1;
    #1;
    n_cmp++; if (sel_chg1 !== 1'b0) begin n_err++; $display("FAIL selchg_in_reset got=%b want=0", sel_chg1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (sel_chg1 !== 1'b1) begin n_err++; $display("FAIL selchg_release got=%b want=1", sel_chg1); end
    // A glitch between edges goes unseen.
    @(negedge clk);
    sel = 1'b0; #2 sel = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (sel_chg1 !== 1'b0) begin n_err++; $display("FAIL selchg_glitch got=%b want=0", sel_chg1); end
  endtask

  task automatic test_x_select();
    logic       exp1;
    logic [7:0] exp8;
    @(negedge clk);
    in1 = 1'b1; in2 = 1'b1; sel = 1'bx;
    #1;
    n_cmp++; if (out1 !== 1'b1) begin n_err++; $display("FAIL x_equal got=%b want=1", out1); end
    in1 = 1'b0;
    #1;
    // A two-state simulator resolves the X; expect the mux of what it chose.
    exp1 = $isunknown(sel) ? 1'bx : (sel ? 1'b1 : 1'b0);
    n_cmp++; if (out1 !== exp1) begin n_err++; $display("FAIL x_differ got=%b want=%b", out1, exp1); end
    in1_8 = 8'hF0; in2_8 = 8'hFF; sel8 = 1'bx;
    #1;
    exp8 = $isunknown(sel8) ? 8'b1111_xxxx : (sel8 ? 8'hFF : 8'hF0);
    n_cmp++; if (out8 !== exp8) begin n_err++; $display("FAIL x_w8_merge got=%b want=%b", out8, exp8); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sweep();
    test_width8();
    test_registered();
    test_async_reset();
    test_sel_chg();
    test_x_select();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_2to1_beh
